mux_scan_ctrl: RTL and testbench

//  Sequencer placed directly upstream of the 8:1 mux (m81). It drives the select lines

---
 rtl/mux_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the m81 8:1 mux: steps sel through the enabled channels,
// samples mux_out after SETTLE idle cycles, and presents the 8-bit snapshot on valid/ready.
module mux_scan_ctrl #(
  parameter int NCH    = 8,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NCH-1:0]         ch_mask,
  input  logic                   mux_out,
  output logic [$clog2(NCH)-1:0] sel,
  output logic                   busy,
  output logic                   out_valid,
  output logic [NCH-1:0]         out_data,
  input  logic                   out_ready,
  output logic [1:0]             state_dbg
);

  localparam int SW = $clog2(NCH);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] mask_q;
  logic [3:0]     cnt;
  logic [SW-1:0]  first_ch;
  logic [SW-1:0]  next_ch;
  logic           next_ok;

  // Handshake: the word transfers on any rising edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that edge.

  // Descending loops leave the lowest qualifying index as the winner.
  always_comb begin
    first_ch = '0;
    next_ch  = sel;
    next_ok  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = SW'(i);
      if (mask_q[i] && (i > int'(sel))) begin
        next_ch = SW'(i);
        next_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = (|ch_mask) ? S_SETTLE : S_OUT;
      end
      S_SETTLE: begin
        if (abort)                           state_nxt = S_IDLE;
        else if ((cnt == 4'd0) && !next_ok)  state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      sel      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            mask_q   <= ch_mask;
            sel      <= first_ch;
            cnt      <= (|ch_mask) ? SETTLE_CNT : 4'd0;
            out_data <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            sel      <= '0;
            cnt      <= '0;
            out_data <= '0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_data[sel] <= mux_out;
            if (next_ok) begin
              sel <= next_ch;
              cnt <= SETTLE_CNT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) sel <= '0;
        end
        default: sel <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table of scans plus hand-written sequences
// for output back-pressure, abort and asynchronous reset.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] state_dbg;
  logic [7:0] d_model = 8'h00;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] d;
    logic [7:0] exp_data;
    int         exp_lat;
    logic [7:0] exp_visit;
    logic [2:0] exp_last_sel;
  } vec_t;

  vec_t vecs[7];

  // 8:1 mux model driven by the sequencer's select lines.
  assign mux_out = d_model[sel];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.NCH(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .mux_out(mux_out), .sel(sel), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept a start, scramble ch_mask and poke start mid-scan, then wait for out_valid.
  task automatic run_scan(input logic [7:0] mask, input logic [7:0] d,
                          output int lat, output logic [7:0] visit);
    @(negedge clk);
    ch_mask = mask;
    d_model = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ch_mask = ~mask;
    lat     = 0;
    visit   = 8'h00;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (out_valid) break;
      if (busy) visit[sel] = 1'b1;
      if (lat == 2) start = 1'b1;
    end
    start = 1'b0;
    if (lat >= 200) check("scan_timeout", 32'(lat), 32'd0);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [7:0] visit;
    logic [7:0] held;

    vecs[0] = '{8'hFF, 8'hA5, 8'hA5, 17, 8'hFF, 3'd7};
    vecs[1] = '{8'h82, 8'hFF, 8'h82,  5, 8'h82, 3'd7};
    vecs[2] = '{8'h00, 8'hFF, 8'h00,  1, 8'h00, 3'd0};
    vecs[3] = '{8'h01, 8'h01, 8'h01,  3, 8'h01, 3'd0};
    vecs[4] = '{8'h80, 8'h00, 8'h00,  3, 8'h80, 3'd7};
    vecs[5] = '{8'h3C, 8'h5A, 8'h18,  9, 8'h3C, 3'd5};
    vecs[6] = '{8'h55, 8'hF0, 8'h50,  9, 8'h55, 3'd6};

    // Reset state
    #12;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_scan(vecs[v].mask, vecs[v].d, lat, visit);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_visit", v), 32'(visit), 32'(vecs[v].exp_visit));
      check($sformatf("v%0d_sel_hold", v), 32'(sel), 32'(vecs[v].exp_last_sel));
      handshake();
      @(negedge clk);
      check($sformatf("v%0d_idle_valid", v), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_idle_sel", v), 32'(sel), 32'd0);
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
    end

    // Back-pressure in OUT: start and abort pulsed, ch_mask changed, word must hold
    run_scan(8'h0F, 8'h09, lat, visit);
    held = out_data;
    check("bp_data", 32'(held), 32'h09);
    for (int c = 0; c < 5; c++) begin
      start   = (c % 2) == 0;
      abort   = (c == 3);
      ch_mask = 8'hF0;
      @(negedge clk);
      check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_stable_%0d", c), 32'(out_data), 32'(held));
    end
    start = 1'b0;
    abort = 1'b0;
    handshake();
    @(negedge clk);
    check("bp_idle_state", 32'(state_dbg), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp_no_new_scan", 32'(busy), 32'd0);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    ch_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_prio_busy", 32'(busy), 32'd0);

    // abort during channel 3 of a full scan
    ch_mask = 8'hFF;
    d_model = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sel == 3'd3) break;
      @(negedge clk);
    end
    check("abort_reach_ch3", 32'(sel), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'(state_dbg), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
    end

    // Asynchronous reset mid-scan
    ch_mask = 8'hF0;
    d_model = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_scan(8'hC3, 8'h42, lat, visit);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_data", 32'(out_data), 32'h42);
    check("post_rst_visit", 32'(visit), 32'hC3);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
